jy_mul_scheduler: RTL
=====================

// Module: jy_mul_scheduler
// PURPOSE
// - Shares one serial 8x8 shift-add multiplier between NREQ requesters, using a round-robin arbiter.
// - Example requesters: JY Company $5800/$5801 register port and a second mapper-side client.
// - Sequences each operation: grant, operand latch, 7 iterations, completion pulse. Result is held.
// - Sits beside the mapper register decode; it replaces per-client multiplier instances.
// PARAMETERS
// - NREQ  2  number of requesters (2..8); index 0 has priority after reset
// PORTS
// - clk        in   1        system clock
// - reset      in   1        asynchronous, active-high reset
// - ce         in   1        M2 clock enable; arbitration and iterations advance only when ce=1
// - req        in   NREQ     level request, one bit per requester
// - op_a       in   8*NREQ   multiplicand, requester i at [8i+7:8i]
// - op_b       in   8*NREQ   multiplier, requester i at [8i+7:8i]
// - ack        out  NREQ     one-clk pulse: requester's operands captured; may drop req
// - done       out  NREQ     one-clk pulse: product valid for that requester
// - product    out  16       result of the last completed operation, held until the next grant
// - busy       out  1        high from grant edge until the DONE cycle, inclusive
// - owner      out  3        index of current/last granted requester
// - accum      out  16       running product sum (JY_MUL_ACCUM_EN only, else 0)
// - accum_clr  in   1        synchronous clear of accum (JY_MUL_ACCUM_EN only, else ignored)
// BEHAVIOUR
// - Reset (async) values: state=IDLE, ack=0, done=0, product=0, busy=0, owner=0,
//   rr_ptr=NREQ-1 (so index 0 wins first), accum=0, iteration count=0.
// - IDLE: on a clk edge with ce=1 and |req:
//   - grant the first set req bit after rr_ptr, scanning upward with wrap.
//   - latch op_a/op_b, set owner and rr_ptr to the granted index.
//   - product <= b[0] ? {8'h0,a} : 0; shift_a <= a<<1; cnt <= 1.
//   - ack[i] <= 1 for one clk; go to RUN.
// - RUN: on each ce=1 edge, product += b[cnt] ? shift_a : 0; shift_a <<= 1; cnt++.
//   After the cnt=7 iteration, go to DONE. ce=0 holds all state.
// - DONE: lasts exactly one clk regardless of ce. done[owner]=1, busy=1. Next edge goes to IDLE.
// - Latency with ce=1: request sampled at edge 0; ack in cycle 1; RUN in cycles 1-7;
//   done in cycle 8; next grant possible at edge 9. One operation takes 9 clks.
// - The product bus is 16 bits and cannot overflow (max 0xFF*0xFF=0xFE01).
//   It changes only at grant and RUN edges; it is stable from DONE until the next grant.
// - req dropped mid-operation: the operation completes and done still pulses.
// - req held through done: the requester is re-eligible in IDLE but ranks last, because rr_ptr = owner.
// - All req bits set at once: grants rotate 0,1,..,NREQ-1,0; no starvation.
//   Worst-case wait is (NREQ-1)*9 clks.
// - ack and done are never high in the same cycle. At most one bit of each is set.
// - Operand changes on op_a/op_b after ack have no effect.
// - Reset asserted mid-RUN aborts the operation: no done pulse, product=0.
// CONFIGURATION
// - JY_MUL_ACCUM_EN defined:
//   - in the DONE cycle, accum <= accum + final product, wrapping mod 2^16.
//   - accum_clr=1 zeroes accum at the next edge and has priority over the DONE add in that cycle.
// - JY_MUL_ACCUM_EN undefined: accum tied to 16'h0, accum_clr unused, no accumulator flops.
// TESTING
// - Single op, ce=1: req[0], a=0x12, b=0x34 -> ack[0] in cycle 1, done[0] in cycle 8,
//   product=0x03A8, busy low by cycle 9.
// - Corners: 0xFF*0xFF -> 0xFE01; 0x00*0xAB -> 0x0000; 0x80*0x02 -> 0x0100.
// - Contention: req=2'b11 held constantly -> grants alternate 0,1,0,1;
//   done pulses 9 clks apart; owner follows.
// - ce every 3rd clk: req[1], 0x0F*0x0F -> each RUN iteration only on ce edges;
//   done after 7 further ce edges; product=0x00E1.
// - Mid-op abort: assert reset in RUN cycle 4 -> no done pulse; all outputs reach reset values immediately.
// - JY_MUL_ACCUM_EN: ops 0x10*0x10 then 0x02*0x03 -> accum=0x0106.
//   accum_clr in the second DONE cycle -> accum=0x0000.

Source files
------------

// File: rtl/jy_mul_scheduler.sv
// Round-robin scheduler sharing one serial 8x8 shift-add multiplier between NREQ requesters.
// Optional running product sum enabled by defining JY_MUL_ACCUM_EN.
module jy_mul_scheduler #(
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   op_a,
    input  logic [8*NREQ-1:0]   op_b,
    input  logic                accum_clr,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     done,
    output logic [15:0]         product,
    output logic                busy,
    output logic [2:0]          owner,
    output logic [15:0]         accum
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [2:0]  rr_ptr_r;
    logic [2:0]  cnt_r;
    logic [15:0] shift_a_r;
    logic [7:0]  shift_b_r;

    logic [7:0]  req_ext_s;
    logic [3:0]  cand_s;
    logic        hit_s;
    logic        grant_found_s;
    logic [2:0]  grant_idx_s;
    logic [7:0]  sel_a_s;
    logic [7:0]  sel_b_s;

    // Pick the first requester after rr_ptr (with wrap) and mux out its operands.
    always_comb begin
        req_ext_s     = 8'(req);
        cand_s        = 4'd0;
        hit_s         = 1'b0;
        grant_found_s = 1'b0;
        grant_idx_s   = 3'd0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s        = {1'b0, rr_ptr_r} + 4'(k);
            cand_s        = (cand_s >= 4'(NREQ)) ? (cand_s - 4'(NREQ)) : cand_s;
            hit_s         = !grant_found_s && req_ext_s[cand_s[2:0]];
            grant_idx_s   = hit_s ? cand_s[2:0] : grant_idx_s;
            grant_found_s = grant_found_s | hit_s;
        end
        sel_a_s = 8'(op_a >> {grant_idx_s, 3'b000});
        sel_b_s = 8'(op_b >> {grant_idx_s, 3'b000});
    end

    // Sequencer: grant/latch, seven shift-add iterations gated by ce, one-clk done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= 3'(NREQ - 1);
            cnt_r     <= 3'd0;
            shift_a_r <= 16'h0000;
            shift_b_r <= 8'h00;
            ack       <= '0;
            done      <= '0;
            product   <= 16'h0000;
            busy      <= 1'b0;
            owner     <= 3'd0;
        end else begin
            ack  <= '0;
            done <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (ce && grant_found_s) begin
                        owner     <= grant_idx_s;
                        rr_ptr_r  <= grant_idx_s;
                        product   <= sel_b_s[0] ? {8'h00, sel_a_s} : 16'h0000;
                        shift_a_r <= {7'h00, sel_a_s, 1'b0};
                        shift_b_r <= {1'b0, sel_b_s[7:1]};
                        cnt_r     <= 3'd1;
                        ack       <= NREQ'(1'b1) << grant_idx_s;
                        busy      <= 1'b1;
                        state_r   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (ce) begin
                        product   <= product + (shift_b_r[0] ? shift_a_r : 16'h0000);
                        shift_a_r <= shift_a_r << 1;
                        shift_b_r <= shift_b_r >> 1;
                        cnt_r     <= cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            done    <= NREQ'(1'b1) << owner;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef JY_MUL_ACCUM_EN
    // Running sum of final products; clear wins over the DONE-cycle add.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accum <= 16'h0000;
        end else if (accum_clr) begin
            accum <= 16'h0000;
        end else if (state_r == ST_DONE) begin
            accum <= accum + product;
        end
    end
`else
    logic unused_accum_clr;
    assign unused_accum_clr = accum_clr;
    assign accum            = 16'h0000;
`endif

endmodule
